// File: rtl/resp_pkg.sv
//------------------------------------------------------------------------------
// resp_pkg : shared constants, state encoding and helpers for resp_stream_tx
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package resp_pkg;

  localparam int DEF_Y_W   = 578;
  localparam int DEF_OUT_W = 32;

  localparam logic [31:0] MISR_TAPS = 32'h0400_0007;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int num_words(input int y_w, input int out_w);
    return (y_w + out_w - 1) / out_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/resp_fifo.sv
//------------------------------------------------------------------------------
// resp_fifo : DEPTH x WIDTH synchronous FIFO, push accepted when full if popping
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module resp_fifo
  import resp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty = (r_wr_ptr == r_rd_ptr);

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/resp_stream_tx.sv
//------------------------------------------------------------------------------
// resp_stream_tx : captures the DUT result bus and streams each sample as words
//                  Optional RESP_MISR_EN adds a 32-bit MISR signature output.
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module resp_stream_tx
  import resp_pkg::*;
#(
  parameter int Y_W   = DEF_Y_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap_en,
  input  logic [Y_W-1:0]   y,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             overflow,
  output logic [15:0]      cap_count
`ifdef RESP_MISR_EN
  ,
  output logic [31:0]      signature
`endif
);

  localparam int   NW       = num_words(Y_W, OUT_W);
  localparam int   SHW      = NW * OUT_W;
  localparam int   IW       = (NW > 1) ? $clog2(NW) : 1;
  localparam logic c_single = (NW == 1);

  state_t           r_state;
  logic [SHW-1:0]   r_shreg;
  logic [IW-1:0]    r_word_idx;
  logic             r_valid;
  logic             r_last;
  logic             r_overflow;
  logic [15:0]      r_cap_count;

  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [Y_W-1:0]   w_fifo_rdata;
  logic             w_hs;
  logic             w_pop;
  logic             w_push_ok;

  assign w_hs      = r_valid && out_ready;
  // Pop when idle, or on the final-word handshake so samples run back-to-back.
  assign w_pop     = !w_fifo_empty && ((r_state == IDLE) || (w_hs && r_last));
  assign w_push_ok = cap_en && (!w_fifo_full || w_pop);

  resp_fifo #(
    .WIDTH (Y_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cap_en),
    .wdata (y),
    .pop   (w_pop),
    .rdata (w_fifo_rdata),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_word_idx <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shreg    <= SHW'(w_fifo_rdata);
            r_word_idx <= '0;
            r_valid    <= 1'b1;
            r_last     <= c_single;
            r_state    <= SEND;
          end
        end
        SEND: begin
          if (w_hs) begin
            if (!r_last) begin
              r_shreg    <= r_shreg >> OUT_W;
              r_word_idx <= r_word_idx + 1'b1;
              r_last     <= (r_word_idx == IW'(NW - 2));
            end else if (w_pop) begin
              r_shreg    <= SHW'(w_fifo_rdata);
              r_word_idx <= '0;
              r_last     <= c_single;
            end else begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_cap_count <= '0;
    end else begin
      if (w_push_ok) r_cap_count <= r_cap_count + 1'b1;
      if (cap_en && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  assign out_data  = r_shreg[OUT_W-1:0];
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign overflow  = r_overflow;
  assign cap_count = r_cap_count;

`ifdef RESP_MISR_EN
  logic [31:0] r_sig;
  logic [31:0] w_word32;

  assign w_word32 = 32'(r_shreg[OUT_W-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (w_hs) begin
      r_sig <= {r_sig[30:0], ^(r_sig & MISR_TAPS)} ^ w_word32;
    end
  end

  assign signature = r_sig;
`else
  // Signature port and MISR are absent in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_resp_stream_tx.sv
//------------------------------------------------------------------------------
// tb_resp_stream_tx : randomized scoreboard bench for resp_stream_tx
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_resp_stream_tx;

  localparam int Y_W   = 578;
  localparam int OUT_W = 32;
  localparam int DEPTH = 4;
  localparam int NW    = 19;
  localparam int PW    = NW * OUT_W;

  logic             clk;
  logic             rst_n;
  logic             cap_en;
  logic [Y_W-1:0]   y;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             overflow;
  logic [15:0]      cap_count;
`ifdef RESP_MISR_EN
  logic [31:0]      signature;
`endif

  resp_stream_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_en    (cap_en),
    .y         (y),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .overflow  (overflow),
    .cap_count (cap_count)
`ifdef RESP_MISR_EN
    ,
    .signature (signature)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of pending samples plus the sample currently on the wire.
  logic [Y_W-1:0]   m_pend[$];
  logic [PW-1:0]    m_cur;
  int               m_left;
  bit               m_busy;
  bit               m_ovf;
  logic [15:0]      m_cnt;
  logic [31:0]      m_sig;
  logic [OUT_W-1:0] exp_d[$];
  bit               exp_l[$];

  bit               m_hs, m_pop, m_acc;
  logic [PW-1:0]    m_pad;
  logic [31:0]      m_word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend.delete();
      exp_d.delete();
      exp_l.delete();
      m_cur  = '0;
      m_left = 0;
      m_busy = 0;
      m_ovf  = 0;
      m_cnt  = '0;
      m_sig  = '0;
    end else begin
      m_hs  = m_busy && out_ready;
      m_pop = (m_pend.size() > 0) && (!m_busy || (m_hs && m_left == 1));
      m_acc = cap_en && ((m_pend.size() < DEPTH) || m_pop);
      if (m_hs) begin
        m_word = m_cur[(NW - m_left) * OUT_W +: OUT_W];
        m_sig  = {m_sig[30:0], ^(m_sig & 32'h0400_0007)} ^ m_word;
        m_left = m_left - 1;
        if (m_left == 0) m_busy = 0;
      end
      if (m_pop) begin
        m_cur  = PW'(m_pend.pop_front());
        m_left = NW;
        m_busy = 1;
      end
      if (m_acc) begin
        m_pend.push_back(y);
        m_cnt = m_cnt + 16'd1;
        m_pad = PW'(y);
        for (int k = 0; k < NW; k++) begin
          exp_d.push_back(m_pad[k * OUT_W +: OUT_W]);
          exp_l.push_back(k == NW - 1);
        end
      end else if (cap_en) begin
        m_ovf = 1;
      end
    end
  end

  // Monitor: compares every observed handshake and status against the model.
  bit               prev_v, prev_r, prev_l;
  logic [OUT_W-1:0] prev_d;
  logic [OUT_W-1:0] e_d;
  bit               e_l;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 0;
    end else begin
      chk("out_valid", 64'(out_valid), 64'(m_busy));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("cap_count", 64'(cap_count), 64'(m_cnt));
      if (prev_v && !prev_r) begin
        chk("hold_data", 64'(out_data), 64'(prev_d));
        chk("hold_last", 64'(out_last), 64'(prev_l));
      end
      if (out_valid && out_ready) begin
        if (exp_d.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", out_data);
        end else begin
          e_d = exp_d.pop_front();
          e_l = exp_l.pop_front();
          chk("out_data", 64'(out_data), 64'(e_d));
          chk("out_last", 64'(out_last), 64'(e_l));
        end
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_d = out_data;
      prev_l = out_last;
    end
  end

  function automatic logic [Y_W-1:0] rand_y();
    logic [PW-1:0] p;
    for (int i = 0; i < NW; i++) p[i * 32 +: 32] = $urandom();
    return p[Y_W-1:0];
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    cap_en    = 1'b0;
    out_ready = 1'b1;
    while ((m_busy || m_pend.size() != 0) && n < 3000) begin
      cycle();
      n++;
    end
    if (n >= 3000) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain_timeout: got busy expected idle");
    end
    cycle();
    chk("drain_empty", 64'(exp_d.size()), 64'd0);
  endtask

  initial begin
    int hs_cnt;
    int bound;
    logic [Y_W-1:0] one_y;

    rst_n     = 1'b0;
    cap_en    = 1'b1;
    out_ready = 1'b1;
    y         = rand_y();

    // Reset with capture requested: nothing may be accepted.
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_last", 64'(out_last), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_count", 64'(cap_count), 64'd0);
    end
    @(posedge clk);
    #1;
    cap_en = 1'b0;
    rst_n  = 1'b1;
    cycle();
    cycle();
    chk("post_rst_count", 64'(cap_count), 64'd0);

    // Single sample with the two extreme bits set.
    one_y      = '0;
    one_y[0]   = 1'b1;
    one_y[577] = 1'b1;
    y      = one_y;
    cap_en = 1'b1;
    cycle();
    cap_en = 1'b0;
    chk("latency_valid_low", 64'(out_valid), 64'd0);
    cycle();
    chk("latency_valid_high", 64'(out_valid), 64'd1);
    drain();
    chk("single_count", 64'(cap_count), 64'd1);

    // Backpressure pattern 1,0,0 repeating.
    y      = rand_y();
    cap_en = 1'b1;
    cycle();
    cap_en = 1'b0;
    for (int i = 0; i < 90; i++) begin
      out_ready = ((i % 3) == 0);
      cycle();
    end
    drain();

    // Overflow: six captures against a stalled sink.
    do_reset();
    out_ready = 1'b0;
    cap_en    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      y = rand_y();
      cycle();
    end
    cap_en = 1'b0;
    cycle();
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(cap_count), 64'd5);
    drain();
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Full FIFO with a capture on the last-word handshake edge.
    do_reset();
    out_ready = 1'b0;
    cap_en    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      y = rand_y();
      cycle();
    end
    cap_en    = 1'b0;
    out_ready = 1'b1;
    bound     = 0;
    while (!(out_valid && out_last) && bound < 100) begin
      cycle();
      bound++;
    end
    if (bound >= 100) begin
      n_vec++;
      n_fail++;
      $display("FAIL full_pop_timeout: got no last word expected one");
    end
    y      = rand_y();
    cap_en = 1'b1;
    cycle();
    cap_en = 1'b0;
    cycle();
    chk("full_pop_overflow", 64'(overflow), 64'd0);
    chk("full_pop_count", 64'(cap_count), 64'd6);
    drain();

    // Mid-stream reset after seven words, then a fresh sample.
    do_reset();
    y      = rand_y();
    cap_en = 1'b1;
    cycle();
    cap_en = 1'b0;
    hs_cnt = 0;
    bound  = 0;
    while (hs_cnt < 7 && bound < 100) begin
      if (out_valid && out_ready) hs_cnt++;
      cycle();
      bound++;
    end
    do_reset();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    y      = rand_y();
    cap_en = 1'b1;
    cycle();
    cap_en = 1'b0;
    drain();
    chk("midrst_count", 64'(cap_count), 64'd1);
`ifdef RESP_MISR_EN
    chk("signature", 64'(signature), 64'(m_sig));
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cap_en    = ($urandom_range(0, 99) < 30);
      out_ready = ($urandom_range(0, 99) < 70);
      y         = rand_y();
      cycle();
    end
    drain();
`ifdef RESP_MISR_EN
    chk("signature_rand", 64'(signature), 64'(m_sig));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
